// File: rtl/i2s_audio_tx.sv
// I2S transmitter: a 9-bit frame counter drives MCLK/SCK/LRCK and a registered SDIN.
// A 16-bit stereo pair is captured once per 512-clk frame on the sample_req strobe.
module i2s_audio_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  output logic        sample_req,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic        audio_sdin
);

  logic [8:0]  cnt, cnt_next;
  logic [15:0] cur_l, cur_r, cur_l_next, cur_r_next;
  logic        prev_r0, prev_r0_next;
  logic        sdin_next;
  logic [3:0]  slot, bit_idx;

  // Strobe is qualified by the live en/rst so a frame cut short never captures.
  assign sample_req = en & ~rst & (cnt == 9'd511);

  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[3];
  assign audio_lrck = cnt[8];

  // SDIN is computed from the post-edge counter and data, so the registered bit
  // always belongs to the slot the counter is entering.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_next     = en ? cnt + 9'd1 : 9'd0;
    cur_l_next   = cur_l;
    cur_r_next   = cur_r;
    prev_r0_next = prev_r0;
    if (sample_req) begin
      prev_r0_next = cur_r[0];
      cur_l_next   = audio_left;
      cur_r_next   = audio_right;
    end

    slot      = cnt_next[7:4];
    bit_idx   = 4'd0 - slot;
    sdin_next = 1'b0;
    if (en) begin
      // One-bit I2S delay: slot 0 carries the previous word's LSB.
      if (!cnt_next[8])
        sdin_next = (slot == 4'd0) ? prev_r0_next : cur_l_next[bit_idx];
      else
        sdin_next = (slot == 4'd0) ? cur_l_next[0] : cur_r_next[bit_idx];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      cnt        <= 9'd0;
      cur_l      <= 16'd0;
      cur_r      <= 16'd0;
      prev_r0    <= 1'b0;
      audio_sdin <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      cur_l      <= cur_l_next;
      cur_r      <= cur_r_next;
      prev_r0    <= prev_r0_next;
      audio_sdin <= sdin_next;
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: a frame-position model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] audio_left, audio_right;
  logic        sample_req, audio_mclk, audio_sck, audio_lrck, audio_sdin;
  logic [4:0]  all_out;

  int n_checks = 0;
  int n_fail   = 0;

  i2s_audio_tx dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .sample_req (sample_req),
    .audio_mclk (audio_mclk),
    .audio_sck  (audio_sck),
    .audio_lrck (audio_lrck),
    .audio_sdin (audio_sdin)
  );

  assign all_out = {sample_req, audio_mclk, audio_sck, audio_lrck, audio_sdin};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Wire bit for frame position pos (0..511) given the pair on air.
  function automatic logic wire_bit(input int pos, input logic [15:0] l, input logic [15:0] r,
                                    input logic p0);
    int half, slot;
    half = pos / 256;
    slot = (pos % 256) / 16;
    if (slot == 0) return (half == 1) ? l[0] : p0;
    return (half == 1) ? r[16 - slot] : l[16 - slot];
  endfunction

  // Model state: frame position, pair on air, last right LSB, expected SDIN.
  bit          m_known = 1'b0;
  int          m_cnt   = 0;
  logic [15:0] m_l, m_r, nl, nr;
  logic        m_p0, m_sdin, np;
  int          nc;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_known = 1'b1;
      m_cnt   = 0;
      m_l     = 16'd0;
      m_r     = 16'd0;
      m_p0    = 1'b0;
      m_sdin  = 1'b0;
    end else if (!en) begin
      m_cnt  = 0;
      m_sdin = 1'b0;
    end else begin
      nl = m_l;
      nr = m_r;
      np = m_p0;
      if (m_cnt == 511) begin
        np = m_r[0];
        nl = audio_left;
        nr = audio_right;
      end
      nc     = (m_cnt + 1) % 512;
      m_cnt  = nc;
      m_l    = nl;
      m_r    = nr;
      m_p0   = np;
      m_sdin = wire_bit(nc, nl, nr, np);
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_known) begin
      check("sample_req", {31'd0, sample_req}, {31'd0, (!rst && en && m_cnt == 511)});
      check("mclk", {31'd0, audio_mclk}, (m_cnt / 2) % 2);
      check("sck", {31'd0, audio_sck}, (m_cnt / 8) % 2);
      check("lrck", {31'd0, audio_lrck}, m_cnt / 256);
      check("sdin", {31'd0, audio_sdin}, {31'd0, m_sdin});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to(input int target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (m_cnt == target) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    if (!found) check("advance_timeout", 0, 1);
  endtask

  // Counts cycles from the current one until sample_req; also records SDIN at offset 24.
  task automatic wait_req(output int gap, output logic s24);
    gap = -1;
    s24 = 1'bx;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (i == 24) s24 = audio_sdin;
      if (sample_req === 1'b1) begin
        gap = i;
        break;
      end
      next_cycle();
    end
    next_cycle();
  endtask

  task automatic drop_en(input int at, input logic exp_s24);
    int   gap;
    logic s24;
    advance_to(at);
    en = 1'b0;
    @(negedge clk);
    check("req_on_drop", {31'd0, sample_req}, 0);
    next_cycle();
    @(negedge clk);
    check("drop_outputs", {27'd0, all_out}, 0);
    repeat (8) next_cycle();
    en = 1'b1;
    wait_req(gap, s24);
    check("resume_req_gap", gap, 511);
    check("resume_slot1", {31'd0, s24}, {31'd0, exp_s24});
  endtask

  int          first_req, n_req, ones, mclk_rise, sck_rise, lrck_rise;
  logic        p_mclk, p_sck, p_lrck, sck255, sck256;
  logic [0:599] bits;

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    audio_left  = 16'h1234;
    audio_right = 16'h1234;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_outputs", {27'd0, all_out}, 0);

    // Release with en=1: cycle 0 is the first cycle with rst low.
    next_cycle();
    rst = 1'b0;
    en  = 1'b1;
    first_req = -1; n_req = 0; ones = 0;
    mclk_rise = 0; sck_rise = 0; lrck_rise = 0;
    p_mclk = 1'b0; p_sck = 1'b0; p_lrck = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (i == 0) check("release_outputs", {27'd0, all_out}, 0);
      if (sample_req) begin
        n_req++;
        if (first_req < 0) first_req = i;
      end
      if (audio_mclk && !p_mclk) mclk_rise++;
      if (audio_sck && !p_sck) sck_rise++;
      if (audio_lrck && !p_lrck) lrck_rise++;
      p_mclk = audio_mclk;
      p_sck  = audio_sck;
      p_lrck = audio_lrck;
      if (i < 512 && audio_sdin) ones++;
      if (i == 255) sck255 = audio_sck;
      if (i == 256) sck256 = audio_sck;
      next_cycle();
    end
    check("first_req_cycle", first_req, 511);
    check("req_count", n_req, 2);
    check("first_frame_ones", ones, 0);
    check("mclk_rises", mclk_rise, 256);
    check("sck_rises", sck_rise, 64);
    check("lrck_rises", lrck_rise, 2);
    check("lrck_on_sck_fall", {30'd0, sck255, sck256}, 2);

    // Capture E000/2000; change left at cnt=100 of the frame that carries it.
    audio_left  = 16'hE000;
    audio_right = 16'h2000;
    repeat (512) next_cycle();
    for (int j = 0; j < 600; j++) begin
      if (j == 100) audio_left = 16'hFFFF;
      @(negedge clk);
      bits[j] = audio_sdin;
      next_cycle();
    end
    begin
      logic [14:0] lslots;
      for (int k = 1; k < 16; k++) lslots[15 - k] = bits[k * 16 + 8];
      check("left_slots_e000", {17'd0, lslots}, 32'h7000);
    end
    check("right_slot0", {31'd0, bits[264]}, 0);
    check("right_slots_1_3", {29'd0, bits[280], bits[296], bits[312]}, 1);
    check("next_left_slot0", {31'd0, bits[520]}, 0);
    check("new_left_slot1", {31'd0, bits[536]}, 1);
    check("new_left_slot4", {31'd0, bits[584]}, 1);

    // en falls on the would-be capture cycle: no capture, held FFFF/2000 resent.
    audio_left  = 16'h0F0F;
    audio_right = 16'h0F0F;
    drop_en(511, 1'b1);
    // Capture of 0F0F occurred at the resume strobe; drop mid-frame at cnt=300.
    drop_en(300, 1'b0);

    // Reset mid-transmission of FFFF/FFFF.
    audio_left  = 16'hFFFF;
    audio_right = 16'hFFFF;
    advance_to(511);
    next_cycle();
    advance_to(200);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    ones = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (i == 0) check("post_reset_outputs", {27'd0, all_out}, 0);
      if (i == 511) check("post_reset_req", {31'd0, sample_req}, 1);
      if (audio_sdin) ones++;
      next_cycle();
    end
    check("post_reset_frame_ones", ones, 0);
    repeat (40) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
